// File: rtl/fft_capture_pkg.sv
// Shared encodings for the FFT capture ping-pong controller.
package fft_capture_pkg;

    localparam int FRAME_LEN_DEFAULT = 1024;

    // Per-bank ownership state.
    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_status_e;

    // Write-side sequencing state.
    typedef enum logic [2:0] {
        W_IDLE  = 3'd0,
        W_ARMED = 3'd1,
        W_FILL  = 3'd2,
        W_WAIT  = 3'd3,
        W_DROP  = 3'd4
    } wr_state_e;

endpackage

// File: rtl/fft_bank_status.sv
// Ownership register for one capture bank. The controller never issues two
// requests for the same bank in one cycle; release wins if it ever did.
module fft_bank_status
    import fft_capture_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         set_filling_i,
    input  logic         set_full_i,
    input  logic         set_reading_i,
    input  logic         release_i,
    output bank_status_e status_o
);

    bank_status_e status_q;
    bank_status_e status_d;

    // Next ownership state from the request strobes.
    always_comb begin
        status_d = status_q;
        if (release_i) begin
            status_d = BANK_FREE;
        end else if (set_filling_i) begin
            status_d = BANK_FILLING;
        end else if (set_full_i) begin
            status_d = BANK_FULL;
        end else if (set_reading_i) begin
            status_d = BANK_READING;
        end
    end

    // Ownership register, cleared to FREE on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= BANK_FREE;
        end else begin
            status_q <= status_d;
        end
    end

    assign status_o = status_q;

endmodule

// File: rtl/fft_capture_bank_ctrl.sv
// Ping-pong bank steering for the FFT capture path.
//
// state   | meaning
// W_IDLE  | between frames; reserve a FREE bank when ENABLE is set
// W_ARMED | bank reserved, waiting for a beat at address 0
// W_FILL  | writing the frame into the reserved bank
// W_WAIT  | enabled but no FREE bank; a frame starting now is dropped
// W_DROP  | discarding the current frame until its end beat
module fft_capture_bank_ctrl
    import fft_capture_pkg::*;
#(
    parameter int BRAM_DEPTH = 10,
    parameter int FRAME_LEN  = FRAME_LEN_DEFAULT,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  ENABLE,
    input  logic                  CAP_W_ENABLE,
    input  logic [BRAM_DEPTH-1:0] CAP_ADDR,
    input  logic                  CAP_LAST,
    output logic                  BANK0_W_ENABLE,
    output logic                  BANK1_W_ENABLE,
    output logic [BRAM_DEPTH-1:0] BANK_ADDR,
    input  logic                  RD_REQ,
    input  logic                  RD_DONE,
    output logic                  RD_GRANT,
    output logic                  RD_BANK,
    output logic                  FRAME_READY,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT,
    output logic [CNT_WIDTH-1:0]  DROP_CNT
);

    localparam logic [BRAM_DEPTH-1:0] LAST_ADDR = BRAM_DEPTH'(FRAME_LEN - 1);

    wr_state_e             state_q, state_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  pref_q, pref_d;
    logic                  oldest_q, oldest_d;
    logic                  rd_grant_q, rd_grant_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  frame_ready_q, frame_ready_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

    bank_status_e          status0, status1;
    logic                  free0, free1, full0, full1;
    logic                  start_beat, end_beat, wr_active;
    logic                  reserve, reserve_bank, complete, disarm, drop;
    logic                  grant, grant_bank, done;
    logic [1:0]            set_filling, set_full, set_reading, release_bank;

    assign free0      = (status0 == BANK_FREE);
    assign free1      = (status1 == BANK_FREE);
    assign full0      = (status0 == BANK_FULL);
    assign full1      = (status1 == BANK_FULL);
    assign start_beat = CAP_W_ENABLE && (CAP_ADDR == '0);
    assign end_beat   = CAP_W_ENABLE && ((CAP_ADDR == LAST_ADDR) || CAP_LAST);

    // Zero-latency write path so data from the capture writer stays aligned.
    assign wr_active      = (state_q == W_FILL) || ((state_q == W_ARMED) && (CAP_ADDR == '0));
    assign BANK0_W_ENABLE = CAP_W_ENABLE && wr_active && !wr_bank_q;
    assign BANK1_W_ENABLE = CAP_W_ENABLE && wr_active && wr_bank_q;
    assign BANK_ADDR      = CAP_ADDR;

    // Write FSM: next state and bank events.
    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        reserve      = 1'b0;
        reserve_bank = 1'b0;
        complete     = 1'b0;
        disarm       = 1'b0;
        drop         = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (ENABLE) begin
                    if (free0 || free1) begin
                        reserve      = 1'b1;
                        reserve_bank = (free0 && free1) ? pref_q : !free0;
                        wr_bank_d    = reserve_bank;
                        state_d      = W_ARMED;
                    end else begin
                        state_d = W_WAIT;
                    end
                end
            end
            W_ARMED: begin
                if (start_beat) begin
                    if (end_beat) begin
                        complete = 1'b1;
                        state_d  = W_IDLE;
                    end else begin
                        state_d = W_FILL;
                    end
                end else if (!ENABLE) begin
                    disarm  = 1'b1;
                    state_d = W_IDLE;
                end
            end
            W_FILL: begin
                if (end_beat) begin
                    complete = 1'b1;
                    state_d  = W_IDLE;
                end
            end
            W_WAIT: begin
                if (free0 || free1 || !ENABLE) begin
                    state_d = W_IDLE;
                end else if (start_beat) begin
                    drop    = 1'b1;
                    state_d = end_beat ? W_IDLE : W_DROP;
                end
            end
            W_DROP: begin
                if (end_beat) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Reader grant/release and the bookkeeping that follows bank events.
    always_comb begin
        grant      = !rd_grant_q && RD_REQ && (full0 || full1);
        grant_bank = (full0 && full1) ? oldest_q : !full0;
        done       = rd_grant_q && RD_DONE;

        rd_grant_d = rd_grant_q;
        rd_bank_d  = rd_bank_q;
        if (grant) begin
            rd_grant_d = 1'b1;
            rd_bank_d  = grant_bank;
        end else if (done) begin
            rd_grant_d = 1'b0;
        end

        pref_d      = pref_q;
        oldest_d    = oldest_q;
        frame_cnt_d = frame_cnt_q;
        if (complete) begin
            pref_d   = !wr_bank_q;
            oldest_d = !oldest_q;
            if (frame_cnt_q != '1) begin
                frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
            end
        end

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end

        frame_ready_d = full0 || full1;

        set_filling[0]  = reserve && !reserve_bank;
        set_filling[1]  = reserve && reserve_bank;
        set_full[0]     = complete && !wr_bank_q;
        set_full[1]     = complete && wr_bank_q;
        set_reading[0]  = grant && !grant_bank;
        set_reading[1]  = grant && grant_bank;
        release_bank[0] = (disarm && !wr_bank_q) || (done && !rd_bank_q);
        release_bank[1] = (disarm && wr_bank_q) || (done && rd_bank_q);
    end

    // Controller registers; reset abandons any frame in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= W_IDLE;
            wr_bank_q     <= 1'b0;
            pref_q        <= 1'b0;
            oldest_q      <= 1'b0;
            rd_grant_q    <= 1'b0;
            rd_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            pref_q        <= pref_d;
            oldest_q      <= oldest_d;
            rd_grant_q    <= rd_grant_d;
            rd_bank_q     <= rd_bank_d;
            frame_ready_q <= frame_ready_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fft_bank_status u_bank0 (
        .clk_i         (ACLK),
        .rst_i         (ARESET),
        .set_filling_i (set_filling[0]),
        .set_full_i    (set_full[0]),
        .set_reading_i (set_reading[0]),
        .release_i     (release_bank[0]),
        .status_o      (status0)
    );

    fft_bank_status u_bank1 (
        .clk_i         (ACLK),
        .rst_i         (ARESET),
        .set_filling_i (set_filling[1]),
        .set_full_i    (set_full[1]),
        .set_reading_i (set_reading[1]),
        .release_i     (release_bank[1]),
        .status_o      (status1)
    );

    assign RD_GRANT    = rd_grant_q;
    assign RD_BANK     = rd_bank_q;
    assign FRAME_READY = frame_ready_q;
    assign FRAME_CNT   = frame_cnt_q;
    assign DROP_CNT    = drop_cnt_q;

endmodule

// File: tb/tb_fft_capture_bank_ctrl.sv
// Directed bench for the FFT capture ping-pong controller.
module tb_fft_capture_bank_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        ENABLE;
    logic        CAP_W_ENABLE;
    logic [9:0]  CAP_ADDR;
    logic        CAP_LAST;
    logic        BANK0_W_ENABLE;
    logic        BANK1_W_ENABLE;
    logic [9:0]  BANK_ADDR;
    logic        RD_REQ;
    logic        RD_DONE;
    logic        RD_GRANT;
    logic        RD_BANK;
    logic        FRAME_READY;
    logic [15:0] FRAME_CNT;
    logic [15:0] DROP_CNT;

    int checks = 0;
    int errors = 0;
    int beat_err = 0;

    fft_capture_bank_ctrl dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .ENABLE         (ENABLE),
        .CAP_W_ENABLE   (CAP_W_ENABLE),
        .CAP_ADDR       (CAP_ADDR),
        .CAP_LAST       (CAP_LAST),
        .BANK0_W_ENABLE (BANK0_W_ENABLE),
        .BANK1_W_ENABLE (BANK1_W_ENABLE),
        .BANK_ADDR      (BANK_ADDR),
        .RD_REQ         (RD_REQ),
        .RD_DONE        (RD_DONE),
        .RD_GRANT       (RD_GRANT),
        .RD_BANK        (RD_BANK),
        .FRAME_READY    (FRAME_READY),
        .FRAME_CNT      (FRAME_CNT),
        .DROP_CNT       (DROP_CNT)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Drive n beats from address start; optional CAP_LAST on the final beat and
    // optional ENABLE drop at a given beat index. Returns per-bank write counts.
    task automatic send_frame(input int start, input int n, input bit use_last,
                              input int en_off_at, output int w0, output int w1);
        w0 = 0;
        w1 = 0;
        for (int i = 0; i < n; i++) begin
            if (i == en_off_at) ENABLE = 1'b0;
            CAP_W_ENABLE = 1'b1;
            CAP_ADDR     = 10'(start + i);
            CAP_LAST     = use_last && (i == n - 1);
            #1;
            if (BANK0_W_ENABLE === 1'b1) w0++;
            if (BANK1_W_ENABLE === 1'b1) w1++;
            if (BANK_ADDR !== CAP_ADDR) beat_err++;
            if ((BANK0_W_ENABLE & BANK1_W_ENABLE) === 1'b1) beat_err++;
            tick();
        end
        CAP_W_ENABLE = 1'b0;
        CAP_ADDR     = '0;
        CAP_LAST     = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; ENABLE = 1'b0; CAP_W_ENABLE = 1'b0; CAP_ADDR = '0;
        CAP_LAST = 1'b0; RD_REQ = 1'b0; RD_DONE = 1'b0;
        repeat (3) tick();
        ARESET = 1'b0;
        tick();
        checks++;
        if ({BANK0_W_ENABLE, BANK1_W_ENABLE, RD_GRANT, RD_BANK, FRAME_READY} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {BANK0_W_ENABLE, BANK1_W_ENABLE, RD_GRANT, RD_BANK, FRAME_READY});
        end
        checks++;
        if (FRAME_CNT !== 16'd0 || DROP_CNT !== 16'd0 || BANK_ADDR !== 10'd0) begin
            errors++;
            $display("FAIL reset_counts got frame=%0d drop=%0d addr=%0d want 0 0 0",
                     FRAME_CNT, DROP_CNT, BANK_ADDR);
        end
    endtask

    task automatic test_single_frame();
        int w0, w1;
        ENABLE = 1'b1;
        tick(); tick();
        send_frame(0, 1024, 1'b0, -1, w0, w1);
        tick(); tick();
        checks++;
        if (w0 !== 1024 || w1 !== 0) begin
            errors++;
            $display("FAIL frame1_writes got b0=%0d b1=%0d want 1024 0", w0, w1);
        end
        checks++;
        if (FRAME_READY !== 1'b1) begin
            errors++;
            $display("FAIL frame1_ready got %b want 1", FRAME_READY);
        end
        checks++;
        if (FRAME_CNT !== 16'd1) begin
            errors++;
            $display("FAIL frame1_cnt got %0d want 1", FRAME_CNT);
        end
    endtask

    task automatic test_back_to_back();
        int w0, w1;
        send_frame(0, 1024, 1'b0, -1, w0, w1);
        tick(); tick();
        checks++;
        if (w0 !== 0 || w1 !== 1024 || FRAME_CNT !== 16'd2) begin
            errors++;
            $display("FAIL frame2 got b0=%0d b1=%0d cnt=%0d want 0 1024 2", w0, w1, FRAME_CNT);
        end
        send_frame(0, 1024, 1'b0, -1, w0, w1);
        ENABLE = 1'b0;
        tick(); tick();
        checks++;
        if (w0 !== 0 || w1 !== 0) begin
            errors++;
            $display("FAIL drop_writes got b0=%0d b1=%0d want 0 0", w0, w1);
        end
        checks++;
        if (DROP_CNT !== 16'd1 || FRAME_CNT !== 16'd2) begin
            errors++;
            $display("FAIL drop_cnt got drop=%0d frame=%0d want 1 2", DROP_CNT, FRAME_CNT);
        end
    endtask

    task automatic test_reader();
        RD_REQ = 1'b1;
        tick();
        checks++;
        if (RD_GRANT !== 1'b1 || RD_BANK !== 1'b0) begin
            errors++;
            $display("FAIL grant_oldest got grant=%b bank=%b want 1 0", RD_GRANT, RD_BANK);
        end
        RD_DONE = 1'b1;
        tick();
        RD_DONE = 1'b0;
        checks++;
        if (RD_GRANT !== 1'b0) begin
            errors++;
            $display("FAIL done_release got grant=%b want 0", RD_GRANT);
        end
        tick();
        checks++;
        if (RD_GRANT !== 1'b1 || RD_BANK !== 1'b1) begin
            errors++;
            $display("FAIL grant_second got grant=%b bank=%b want 1 1", RD_GRANT, RD_BANK);
        end
        tick();
        checks++;
        if (FRAME_READY !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_read got %b want 0", FRAME_READY);
        end
        RD_REQ  = 1'b0;
        RD_DONE = 1'b1;
        tick();
        RD_DONE = 1'b0;
        tick();
        checks++;
        if (RD_GRANT !== 1'b0) begin
            errors++;
            $display("FAIL idle_grant got %b want 0", RD_GRANT);
        end
    endtask

    task automatic test_cap_last();
        int w0, w1;
        ENABLE = 1'b1;
        tick(); tick();
        send_frame(0, 300, 1'b1, -1, w0, w1);
        tick(); tick();
        checks++;
        if (w0 !== 300 || w1 !== 0 || FRAME_CNT !== 16'd3) begin
            errors++;
            $display("FAIL cap_last got b0=%0d b1=%0d cnt=%0d want 300 0 3", w0, w1, FRAME_CNT);
        end
    endtask

    task automatic test_enable_drop();
        int w0, w1;
        send_frame(0, 1024, 1'b0, 500, w0, w1);
        tick(); tick();
        checks++;
        if (w0 !== 0 || w1 !== 1024 || FRAME_CNT !== 16'd4) begin
            errors++;
            $display("FAIL enable_drop got b0=%0d b1=%0d cnt=%0d want 0 1024 4", w0, w1, FRAME_CNT);
        end
        send_frame(0, 1024, 1'b0, -1, w0, w1);
        tick();
        checks++;
        if (w0 !== 0 || w1 !== 0 || FRAME_CNT !== 16'd4 || DROP_CNT !== 16'd1) begin
            errors++;
            $display("FAIL disabled_frame got b0=%0d b1=%0d cnt=%0d drop=%0d want 0 0 4 1",
                     w0, w1, FRAME_CNT, DROP_CNT);
        end
        checks++;
        if (FRAME_READY !== 1'b1) begin
            errors++;
            $display("FAIL both_full_ready got %b want 1", FRAME_READY);
        end
    endtask

    task automatic test_reset_mid();
        int w0, w1;
        RD_REQ = 1'b1;
        tick();
        checks++;
        if (RD_GRANT !== 1'b1 || RD_BANK !== 1'b0) begin
            errors++;
            $display("FAIL both_full_oldest got grant=%b bank=%b want 1 0", RD_GRANT, RD_BANK);
        end
        RD_DONE = 1'b1;
        tick();
        RD_DONE = 1'b0;
        ENABLE  = 1'b1;
        tick(); tick();
        checks++;
        if (RD_GRANT !== 1'b1 || RD_BANK !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_grant got grant=%b bank=%b want 1 1", RD_GRANT, RD_BANK);
        end
        send_frame(0, 700, 1'b0, -1, w0, w1);
        checks++;
        if (w0 !== 700 || w1 !== 0) begin
            errors++;
            $display("FAIL partial_writes got b0=%0d b1=%0d want 700 0", w0, w1);
        end
        ARESET = 1'b1; CAP_W_ENABLE = 1'b1; CAP_ADDR = 10'd700;
        tick();
        ARESET = 1'b0; CAP_W_ENABLE = 1'b0; CAP_ADDR = '0;
        #1;
        checks++;
        if ({BANK0_W_ENABLE, BANK1_W_ENABLE, RD_GRANT, RD_BANK, FRAME_READY} !== 5'b0
            || FRAME_CNT !== 16'd0 || DROP_CNT !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got flags=%b frame=%0d drop=%0d want 00000 0 0",
                     {BANK0_W_ENABLE, BANK1_W_ENABLE, RD_GRANT, RD_BANK, FRAME_READY},
                     FRAME_CNT, DROP_CNT);
        end
        repeat (3) tick();
        checks++;
        if (RD_GRANT !== 1'b0 || FRAME_READY !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_no_full got grant=%b ready=%b want 0 0", RD_GRANT, FRAME_READY);
        end
        RD_REQ = 1'b0;
    endtask

    task automatic test_mid_join();
        int w0, w1;
        send_frame(10, 10, 1'b0, -1, w0, w1);
        checks++;
        if (w0 !== 0 || w1 !== 0) begin
            errors++;
            $display("FAIL mid_join got b0=%0d b1=%0d want 0 0", w0, w1);
        end
        tick(); tick();
        send_frame(0, 10, 1'b1, -1, w0, w1);
        tick(); tick();
        checks++;
        if (w0 !== 10 || w1 !== 0 || FRAME_CNT !== 16'd1) begin
            errors++;
            $display("FAIL after_join got b0=%0d b1=%0d cnt=%0d want 10 0 1", w0, w1, FRAME_CNT);
        end
    endtask

    task automatic test_datapath();
        checks++;
        if (beat_err !== 0) begin
            errors++;
            $display("FAIL datapath got %0d bad beats want 0", beat_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reader();
        test_cap_last();
        test_enable_drop();
        test_reset_mid();
        test_mid_join();
        test_datapath();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
